// File: rtl/fineps_phase_controller.sv
// Fine-phase-shift initiator for the clock synthesizer.
// Takes an absolute target position, picks the shortest signed path around
// the circular step range, then walks there one handshaked step at a time.
module fineps_phase_controller #(
    parameter int INT_STEPS_PER_WRAP = 1120,
    parameter int INT_POS_WIDTH      = 16,
    parameter int INT_TIMEOUT_CYCLES = 1024
) (
    input  logic                     in_clk,
    input  logic                     in_rst,
    input  logic                     in_locked,
    input  logic                     in_target_valid,
    input  logic [INT_POS_WIDTH-1:0] in_target_pos,
    output logic                     out_target_ready,
    output logic                     out_fineps_valid,
    output logic                     out_fineps_incr,
    output logic                     out_fineps_decr,
    input  logic                     in_fineps_dready,
    output logic [INT_POS_WIDTH-1:0] out_cur_pos,
    output logic                     out_busy,
    output logic                     out_done,
    output logic                     out_error
);

    localparam int W  = INT_POS_WIDTH;
    localparam int TW = $clog2(INT_TIMEOUT_CYCLES + 1);

    localparam logic [W:0]    N_EXT    = (W+1)'(INT_STEPS_PER_WRAP);
    localparam logic [W:0]    HALF_EXT = (W+1)'(INT_STEPS_PER_WRAP / 2);
    localparam logic [W-1:0]  POS_MAX  = W'(INT_STEPS_PER_WRAP - 1);
    localparam logic [TW-1:0] T_LAST   = TW'(INT_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PLAN,
        ISSUE,
        GUARD,
        WAIT_DONE,
        FINISH
    } state_t;

    state_t        state, state_next;
    logic [W-1:0]  cur_pos, cur_pos_next;
    logic [W-1:0]  target_pos, target_next;
    logic [W-1:0]  step_cnt, step_next;
    logic          dir_incr, dir_next;
    logic [TW-1:0] tcnt, tcnt_next;

    logic          ready_next, valid_next, incr_next, decr_next;
    logic          busy_next, done_next, error_next;

    logic [W:0]    delta;
    logic [W:0]    back_steps;

    // Forward distance from current to target around the wrap, and its complement.
    always_comb begin
        delta = '0;
        if (target_pos >= cur_pos) begin
            delta = {1'b0, target_pos} - {1'b0, cur_pos};
        end else begin
            delta = {1'b0, target_pos} + N_EXT - {1'b0, cur_pos};
        end
        back_steps = N_EXT - delta;
    end

    // Next-state and next-output logic; lock loss overrides every state.
    always_comb begin
        state_next   = state;
        cur_pos_next = cur_pos;
        target_next  = target_pos;
        step_next    = step_cnt;
        dir_next     = dir_incr;
        tcnt_next    = tcnt;
        valid_next   = 1'b0;
        incr_next    = 1'b0;
        decr_next    = 1'b0;
        done_next    = 1'b0;
        error_next   = 1'b0;

        if (!in_locked) begin
            state_next   = IDLE;
            cur_pos_next = '0;
            tcnt_next    = '0;
            error_next   = (state != IDLE);
        end else begin
            case (state)
                IDLE: begin
                    if (in_target_valid && out_target_ready) begin
                        if ({1'b0, in_target_pos} >= N_EXT) begin
                            error_next = 1'b1;
                        end else begin
                            target_next = in_target_pos;
                            state_next  = PLAN;
                        end
                    end
                end
                PLAN: begin
                    tcnt_next = '0;
                    if (delta == '0) begin
                        state_next = FINISH;
                    end else if (delta <= HALF_EXT) begin
                        dir_next   = 1'b1;
                        step_next  = delta[W-1:0];
                        state_next = ISSUE;
                    end else begin
                        dir_next   = 1'b0;
                        step_next  = back_steps[W-1:0];
                        state_next = ISSUE;
                    end
                end
                ISSUE: begin
                    if (in_fineps_dready) begin
                        valid_next = 1'b1;
                        incr_next  = dir_incr;
                        decr_next  = !dir_incr;
                        tcnt_next  = '0;
                        state_next = GUARD;
                    end else if (tcnt == T_LAST) begin
                        error_next = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tcnt_next = tcnt + TW'(1);
                    end
                end
                GUARD: begin
                    tcnt_next  = tcnt + TW'(1);
                    state_next = WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tcnt == T_LAST) begin
                        error_next = 1'b1;
                        state_next = IDLE;
                    end else if (in_fineps_dready) begin
                        if (dir_incr) begin
                            cur_pos_next = (cur_pos == POS_MAX) ? '0 : cur_pos + W'(1);
                        end else begin
                            cur_pos_next = (cur_pos == '0) ? POS_MAX : cur_pos - W'(1);
                        end
                        step_next  = step_cnt - W'(1);
                        tcnt_next  = '0;
                        state_next = (step_cnt == W'(1)) ? FINISH : ISSUE;
                    end else begin
                        tcnt_next = tcnt + TW'(1);
                    end
                end
                FINISH: begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end

        ready_next = in_locked && (state_next == IDLE);
        busy_next  = (state_next != IDLE);
    end

    // State, datapath and registered outputs; synchronous reset clears all.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state            <= IDLE;
            cur_pos          <= '0;
            target_pos       <= '0;
            step_cnt         <= '0;
            dir_incr         <= 1'b0;
            tcnt             <= '0;
            out_target_ready <= 1'b0;
            out_fineps_valid <= 1'b0;
            out_fineps_incr  <= 1'b0;
            out_fineps_decr  <= 1'b0;
            out_busy         <= 1'b0;
            out_done         <= 1'b0;
            out_error        <= 1'b0;
        end else begin
            state            <= state_next;
            cur_pos          <= cur_pos_next;
            target_pos       <= target_next;
            step_cnt         <= step_next;
            dir_incr         <= dir_next;
            tcnt             <= tcnt_next;
            out_target_ready <= ready_next;
            out_fineps_valid <= valid_next;
            out_fineps_incr  <= incr_next;
            out_fineps_decr  <= decr_next;
            out_busy         <= busy_next;
            out_done         <= done_next;
            out_error        <= error_next;
        end
    end

    assign out_cur_pos = cur_pos;

endmodule

// File: tb/tb_fineps_phase_controller.sv
// Directed bench for fineps_phase_controller with a latency-programmable
// dready responder standing in for the synthesizer.
module tb_fineps_phase_controller;

    logic        in_clk = 1'b0;
    logic        in_rst = 1'b1;
    logic        in_locked = 1'b0;
    logic        in_target_valid = 1'b0;
    logic [15:0] in_target_pos = '0;
    logic        in_fineps_dready = 1'b1;
    logic        out_target_ready;
    logic        out_fineps_valid;
    logic        out_fineps_incr;
    logic        out_fineps_decr;
    logic [15:0] out_cur_pos;
    logic        out_busy;
    logic        out_done;
    logic        out_error;

    int checks = 0;
    int failures = 0;

    int respLat = 12;
    logic respHang = 1'b0;
    int respCnt = 0;

    int nValid, nIncr, nDecr, nBadDir, nDone, nErr;
    int firstValid, doneAt, errAt;
    logic timedOut;
    logic [15:0] posLog[$];

    fineps_phase_controller dut (
        .in_clk           (in_clk),
        .in_rst           (in_rst),
        .in_locked        (in_locked),
        .in_target_valid  (in_target_valid),
        .in_target_pos    (in_target_pos),
        .out_target_ready (out_target_ready),
        .out_fineps_valid (out_fineps_valid),
        .out_fineps_incr  (out_fineps_incr),
        .out_fineps_decr  (out_fineps_decr),
        .in_fineps_dready (in_fineps_dready),
        .out_cur_pos      (out_cur_pos),
        .out_busy         (out_busy),
        .out_done         (out_done),
        .out_error        (out_error)
    );

    always #5 in_clk = ~in_clk;

    // Responder: drops dready on seeing valid, raises it again respLat cycles later.
    always @(negedge in_clk) begin
        if (out_fineps_valid) begin
            respCnt = respLat;
        end else if (respCnt > 0 && !respHang) begin
            respCnt = respCnt - 1;
        end
        in_fineps_dready = (respCnt == 0);
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one target for one edge; returns on the negedge after acceptance.
    task automatic applyStimulus(input string tag, input logic [15:0] pos);
        checkOutput({tag, "_ready"}, 32'(out_target_ready), 32'd1);
        in_target_pos   = pos;
        in_target_valid = 1'b1;
        @(negedge in_clk);
        in_target_valid = 1'b0;
    endtask

    // Observe the DUT each negedge until done or error, counting events.
    task automatic waitResult(input int budget);
        int j;
        logic stop;
        logic [15:0] prevPos;
        nValid = 0; nIncr = 0; nDecr = 0; nBadDir = 0; nDone = 0; nErr = 0;
        firstValid = -1; doneAt = -1; errAt = -1; timedOut = 1'b0;
        posLog.delete();
        prevPos = out_cur_pos;
        j = 0;
        stop = 1'b0;
        while (!stop) begin
            if (out_fineps_valid) begin
                nValid++;
                if (firstValid < 0) firstValid = j;
                if (out_fineps_incr == out_fineps_decr) nBadDir++;
            end
            if (out_fineps_incr) nIncr++;
            if (out_fineps_decr) nDecr++;
            if (out_cur_pos != prevPos) begin
                posLog.push_back(out_cur_pos);
                prevPos = out_cur_pos;
            end
            if (out_done) begin nDone++; doneAt = j; stop = 1'b1; end
            if (out_error) begin nErr++; errAt = j; stop = 1'b1; end
            if (!stop) begin
                if (j >= budget) begin
                    timedOut = 1'b1;
                    stop = 1'b1;
                end else begin
                    @(negedge in_clk);
                    j++;
                end
            end
        end
        checkOutput("wait_budget", 32'(timedOut), 32'd0);
    endtask

    initial begin
        // Reset with lock low, then lock, then release reset.
        repeat (3) @(negedge in_clk);
        checkOutput("rst_ready", 32'(out_target_ready), 32'd0);
        checkOutput("rst_valid", 32'(out_fineps_valid), 32'd0);
        checkOutput("rst_busy", 32'(out_busy), 32'd0);
        checkOutput("rst_done", 32'(out_done), 32'd0);
        checkOutput("rst_error", 32'(out_error), 32'd0);
        checkOutput("rst_pos", 32'(out_cur_pos), 32'd0);
        in_rst = 1'b0;
        @(negedge in_clk);
        checkOutput("unlocked_ready", 32'(out_target_ready), 32'd0);
        in_locked = 1'b1;
        @(negedge in_clk);
        checkOutput("locked_ready", 32'(out_target_ready), 32'd1);

        $display("[TB] forward 0 -> 5");
        respLat = 12;
        applyStimulus("fwd", 16'd5);
        checkOutput("fwd_ready_fall", 32'(out_target_ready), 32'd0);
        checkOutput("fwd_busy", 32'(out_busy), 32'd1);
        waitResult(400);
        checkOutput("fwd_nvalid", 32'(nValid), 32'd5);
        checkOutput("fwd_nincr", 32'(nIncr), 32'd5);
        checkOutput("fwd_ndecr", 32'(nDecr), 32'd0);
        checkOutput("fwd_baddir", 32'(nBadDir), 32'd0);
        checkOutput("fwd_first_valid", 32'(firstValid), 32'd2);
        checkOutput("fwd_ndone", 32'(nDone), 32'd1);
        checkOutput("fwd_pos", 32'(out_cur_pos), 32'd5);
        @(negedge in_clk);
        checkOutput("fwd_done_pulse", 32'(out_done), 32'd0);
        checkOutput("fwd_idle_busy", 32'(out_busy), 32'd0);

        $display("[TB] decrement 5 -> 2 -> 1117 across wrap");
        applyStimulus("dec1", 16'd2);
        waitResult(400);
        checkOutput("dec1_ndecr", 32'(nDecr), 32'd3);
        checkOutput("dec1_pos", 32'(out_cur_pos), 32'd2);
        applyStimulus("wrap", 16'd1117);
        waitResult(400);
        checkOutput("wrap_ndecr", 32'(nDecr), 32'd5);
        checkOutput("wrap_nincr", 32'(nIncr), 32'd0);
        checkOutput("wrap_nlog", 32'(posLog.size()), 32'd5);
        checkOutput("wrap_seq0", 32'(posLog[0]), 32'd1);
        checkOutput("wrap_seq1", 32'(posLog[1]), 32'd0);
        checkOutput("wrap_seq2", 32'(posLog[2]), 32'd1119);
        checkOutput("wrap_seq3", 32'(posLog[3]), 32'd1118);
        checkOutput("wrap_seq4", 32'(posLog[4]), 32'd1117);

        $display("[TB] forward 1117 -> 0 across wrap, fast responder");
        respLat = 1;
        applyStimulus("upwrap", 16'd0);
        waitResult(100);
        checkOutput("upwrap_nincr", 32'(nIncr), 32'd3);
        checkOutput("upwrap_pos", 32'(out_cur_pos), 32'd0);

        $display("[TB] half-period tie 0 -> 560");
        applyStimulus("tie", 16'd560);
        waitResult(2000);
        checkOutput("tie_nvalid", 32'(nValid), 32'd560);
        checkOutput("tie_nincr", 32'(nIncr), 32'd560);
        checkOutput("tie_ndecr", 32'(nDecr), 32'd0);
        checkOutput("tie_pos", 32'(out_cur_pos), 32'd560);

        $display("[TB] zero delta 560 -> 560");
        applyStimulus("zero", 16'd560);
        waitResult(20);
        checkOutput("zero_nvalid", 32'(nValid), 32'd0);
        checkOutput("zero_done_at", 32'(doneAt), 32'd2);

        $display("[TB] just past half 560 -> 1 goes decr");
        applyStimulus("past", 16'd1);
        waitResult(2000);
        checkOutput("past_ndecr", 32'(nDecr), 32'd559);
        checkOutput("past_nincr", 32'(nIncr), 32'd0);
        checkOutput("past_pos", 32'(out_cur_pos), 32'd1);

        $display("[TB] reject target 1120");
        applyStimulus("rej", 16'd1120);
        waitResult(10);
        checkOutput("rej_err_at", 32'(errAt), 32'd0);
        checkOutput("rej_busy", 32'(out_busy), 32'd0);
        checkOutput("rej_ready", 32'(out_target_ready), 32'd1);
        nValid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge in_clk);
            if (out_fineps_valid || out_busy) nValid++;
        end
        checkOutput("rej_quiet", 32'(nValid), 32'd0);
        checkOutput("rej_pos", 32'(out_cur_pos), 32'd1);

        $display("[TB] timeout with silent responder");
        respHang = 1'b1;
        respLat = 3;
        applyStimulus("tmo", 16'd3);
        waitResult(1200);
        checkOutput("tmo_nvalid", 32'(nValid), 32'd1);
        checkOutput("tmo_first_valid", 32'(firstValid), 32'd2);
        checkOutput("tmo_gap", 32'(errAt - firstValid), 32'd1024);
        checkOutput("tmo_pos", 32'(out_cur_pos), 32'd1);
        checkOutput("tmo_busy", 32'(out_busy), 32'd0);
        checkOutput("tmo_ready", 32'(out_target_ready), 32'd1);
        respHang = 1'b0;
        repeat (6) @(negedge in_clk);

        $display("[TB] lock drop mid-sweep");
        respLat = 12;
        applyStimulus("lock", 16'd100);
        repeat (60) @(negedge in_clk);
        checkOutput("lock_busy_before", 32'(out_busy), 32'd1);
        in_locked = 1'b0;
        @(negedge in_clk);
        checkOutput("lock_error", 32'(out_error), 32'd1);
        checkOutput("lock_pos", 32'(out_cur_pos), 32'd0);
        checkOutput("lock_busy", 32'(out_busy), 32'd0);
        checkOutput("lock_ready", 32'(out_target_ready), 32'd0);
        checkOutput("lock_valid", 32'(out_fineps_valid), 32'd0);
        @(negedge in_clk);
        checkOutput("lock_error_pulse", 32'(out_error), 32'd0);
        checkOutput("lock_ready_held", 32'(out_target_ready), 32'd0);
        in_locked = 1'b1;
        @(negedge in_clk);
        checkOutput("lock_ready_back", 32'(out_target_ready), 32'd1);
        repeat (20) @(negedge in_clk);

        $display("[TB] reset mid-step");
        applyStimulus("rst", 16'd10);
        repeat (40) @(negedge in_clk);
        checkOutput("rst_busy_before", 32'(out_busy), 32'd1);
        in_rst = 1'b1;
        @(negedge in_clk);
        checkOutput("midrst_ready", 32'(out_target_ready), 32'd0);
        checkOutput("midrst_valid", 32'(out_fineps_valid), 32'd0);
        checkOutput("midrst_incr", 32'(out_fineps_incr), 32'd0);
        checkOutput("midrst_decr", 32'(out_fineps_decr), 32'd0);
        checkOutput("midrst_busy", 32'(out_busy), 32'd0);
        checkOutput("midrst_done", 32'(out_done), 32'd0);
        checkOutput("midrst_error", 32'(out_error), 32'd0);
        checkOutput("midrst_pos", 32'(out_cur_pos), 32'd0);
        in_rst = 1'b0;
        @(negedge in_clk);
        checkOutput("midrst_ready_back", 32'(out_target_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fineps_phase_controller.md
# fineps_phase_controller

Initiator for the clock synthesizer's fine-phase-shift handshake. It accepts an absolute target phase position and computes the shortest signed path on a circular step range. It then issues one incr/decr request per step on the synthesizer's `valid`/`incr`/`decr`/`dready` interface until the target is reached. It sits in the `in_fineps_clk` domain beside the synthesizer and is driven by calibration/sweep logic.

## Interface
- `INT_STEPS_PER_WRAP`, default 1120: number of fine steps in one full output-clock period. Position is taken modulo this value. Legal range is 2 up to 2^INT_POS_WIDTH-1.
- `INT_POS_WIDTH`, default 16: width of position and target.
- `INT_TIMEOUT_CYCLES`, default 1024: maximum number of cycles to wait for `dready` per step.

Ports:
- `in_clk` input 1: single clock. It is the same clock as the synthesizer's `in_fineps_clk`.
- `in_rst` input 1: synchronous, active-high reset.
- `in_locked` input 1: synthesizer `locked`.
- `in_target_valid` input 1: a target request is presented.
- `in_target_pos` input INT_POS_WIDTH: requested absolute position.
- `out_target_ready` output 1: high in IDLE only, and only while `in_locked` = 1.
- `out_fineps_valid` output 1: one-cycle step request.
- `out_fineps_incr` output 1: step direction is +1.
- `out_fineps_decr` output 1: step direction is −1.
- `in_fineps_dready` input 1: synthesizer ready (its `out_fineps_dready`).
- `out_cur_pos` output INT_POS_WIDTH: current tracked position.
- `out_busy` output 1: high in any state other than IDLE.
- `out_done` output 1: one-cycle pulse when the target is reached.
- `out_error` output 1: one-cycle pulse on rejection, timeout or lock loss.

## Operation
States: IDLE, PLAN, ISSUE, GUARD, WAIT_DONE, FINISH. All outputs are registered.

Reset (`in_rst` = 1 at an edge) puts the block in IDLE with every output at 0 and the internal step counter at 0. `out_target_ready` rises on the first post-reset cycle where `in_locked` = 1.

- **IDLE:**
  - A target is accepted when `in_target_valid` and `out_target_ready` are both high.
  - If `in_target_pos` ≥ INT_STEPS_PER_WRAP, the request is rejected: `out_error` pulses and the block stays in IDLE.
  - Otherwise the target is latched and the block moves to PLAN.
- **PLAN:**
  - Compute delta = (target − cur_pos) mod N, where N = INT_STEPS_PER_WRAP. Intermediates are INT_POS_WIDTH+1 bits wide.
  - If delta = 0, go to FINISH.
  - If delta ≤ N/2 (integer floor), the direction is incr and the step count is delta. An exact half-period tie goes incr.
  - Otherwise the direction is decr and the step count is N − delta.
  - Then go to ISSUE.
- **ISSUE:**
  - Wait until `in_fineps_dready` = 1.
  - In that cycle, register `out_fineps_valid` = 1 for exactly one cycle. Exactly one of `out_fineps_incr`/`out_fineps_decr` is 1; the other is 0.
  - Go to GUARD.
- **GUARD:** one cycle in which `dready` is ignored. This covers the responder dropping `dready` one cycle after it samples `valid`. Then go to WAIT_DONE.
- **WAIT_DONE:**
  - When `in_fineps_dready` = 1, the step is complete:
    - `cur_pos` moves by ±1 modulo N: incr at N−1 wraps to 0, decr at 0 wraps to N−1.
    - The step count decrements.
    - If the count is now 0, go to FINISH; otherwise go to ISSUE.
  - A timeout counter runs in ISSUE and WAIT_DONE and is cleared on every valid issue. If it reaches INT_TIMEOUT_CYCLES, `out_error` pulses, the block returns to IDLE, and `cur_pos` keeps its last confirmed value.
- **FINISH:** `out_done` pulses for one cycle, then the block returns to IDLE.

Lock loss (`in_locked` = 0 in any state):
- Next state is IDLE; any pending step is abandoned.
- `cur_pos` is set to 0, because the MMCM restarts at zero shift.
- `out_error` pulses if the block was busy.
- `out_fineps_*` are forced to 0.

Simultaneous events:
- `in_rst` has priority over lock loss, and lock loss over everything else.
- Within a cycle, timeout has priority over `dready` in WAIT_DONE.

## Timing
Target accepted at edge T:
- PLAN at T+1.
- First `out_fineps_valid` at T+2, provided `dready` is already high.
- Minimum step period is 3 cycles (ISSUE, GUARD, WAIT_DONE) when `dready` returns immediately. Each real MMCM step is bounded by the PSDONE latency of about 12 PSCLK cycles.
- `out_cur_pos` updates one cycle after `dready` is seen in WAIT_DONE.
- When delta = 0, `out_done` appears at T+2.
- `out_target_ready` falls the cycle after acceptance.

## Test plan
- **Forward steps:** N = 1120, cur = 0, target = 5, responder model returns `dready` 12 cycles after `valid`. Require exactly 5 valid pulses, each with incr = 1 and decr = 0; `out_cur_pos` = 5; one `out_done` pulse; first valid at T+2.
- **Wrap, decrement:** cur = 2, target = 1117. Require 5 decr pulses and `out_cur_pos` sequence 1, 0, 1119, 1118, 1117.
- **Tie and zero delta:**
  - cur = 0, target = 560: require 560 incr pulses.
  - target equal to cur: require zero valid pulses and `out_done` at T+2.
- **Rejection:** target = 1120. Require an `out_error` pulse, no valid pulse, and the block stays in IDLE.
- **Timeout:** responder never returns `dready`. Require an `out_error` pulse 1024 cycles after the valid pulse, return to IDLE, and `cur_pos` unchanged.
- **Lock drop and reset:**
  - Drop `in_locked` mid-sweep: require an `out_error` pulse, `cur_pos` = 0, and `out_target_ready` low until lock returns.
  - Assert `in_rst` mid-step: require all outputs at 0 next cycle.
